// File: rtl/dma_regs_pkg.sv
// Shared register offsets, bit positions and response codes for the DMA MMIO block.
// Also provides the byte-strobe merge used by every RW register.
package dma_regs_pkg;

  localparam logic [5:0] REG_CTRL      = 6'h00;
  localparam logic [5:0] REG_STATUS    = 6'h04;
  localparam logic [5:0] REG_RX_SRC_LO = 6'h08;
  localparam logic [5:0] REG_RX_SRC_HI = 6'h0C;
  localparam logic [5:0] REG_RX_LEN    = 6'h10;
  localparam logic [5:0] REG_TX_DST_LO = 6'h14;
  localparam logic [5:0] REG_TX_DST_HI = 6'h18;
  localparam logic [5:0] REG_TX_LEN    = 6'h1C;
  localparam logic [5:0] REG_ID        = 6'h20;

  localparam int CTRL_START_RX  = 0;
  localparam int CTRL_START_TX  = 1;
  localparam int CTRL_IRQ_EN_RX = 2;
  localparam int CTRL_IRQ_EN_TX = 3;

  localparam int ST_BUSY_RX      = 0;
  localparam int ST_DONE_RX      = 1;
  localparam int ST_BUSY_TX      = 2;
  localparam int ST_DONE_TX      = 3;
  localparam int ST_RX_PEND      = 4;
  localparam int ST_TX_PEND      = 5;
  localparam int ST_RX_START_ERR = 6;
  localparam int ST_TX_START_ERR = 7;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [31:0] ID_VALUE_DEFAULT = 32'hD0A1_0001;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = new_val[8*b +: 8];
    return r;
  endfunction

  function automatic logic is_mapped(input logic [5:0] off);
    return off <= REG_ID;
  endfunction

endpackage

// File: rtl/dma_mmio_regs.sv
// AXI4-Lite control/status registers for the duplex AXI-stream DMA: start pulses,
// operand registers, pending/error flags and a registered level interrupt.
module dma_mmio_regs
  import dma_regs_pkg::*;
#(
  parameter int          ADDR_W   = 12,
  parameter logic [31:0] ID_VALUE = ID_VALUE_DEFAULT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic              start_rx,
  output logic [63:0]       src_addr_rx,
  output logic [31:0]       len_pkts_rx,
  input  logic              busy_rx,
  input  logic              done_rx,
  output logic              start_tx,
  output logic [63:0]       dst_addr_tx,
  output logic [31:0]       len_pkts_tx,
  input  logic              busy_tx,
  input  logic              done_tx,
  output logic              irq
);

  logic        aw_held, w_held;
  logic [5:0]  aw_off;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        commit, ctrl_wr;
  logic [7:0]  w1c;
  logic [5:0]  ar_off;
  logic [31:0] rd_data;
  logic        irq_en_rx, irq_en_tx;
  logic        rx_pend, tx_pend, rx_err, tx_err;
  logic        done_rx_q, done_tx_q;
  logic        unused_addr_bits;

  assign s_awready = !aw_held;
  assign s_wready  = !w_held;
  assign s_arready = !s_rvalid;
  assign ar_off    = {s_araddr[5:2], 2'b00};
  assign unused_addr_bits = ^{s_awaddr[ADDR_W-1:6], s_awaddr[1:0],
                              s_araddr[ADDR_W-1:6], s_araddr[1:0]};

  // A write commits only once both halves are held and the previous response is gone
  assign commit  = aw_held && w_held && !s_bvalid;
  assign ctrl_wr = commit && (aw_off == REG_CTRL) && w_strb[0];
  assign w1c     = (commit && (aw_off == REG_STATUS) && w_strb[0]) ? w_data[7:0] : 8'h00;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_off   <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      s_bvalid <= 1'b0;
      s_bresp  <= RESP_OKAY;
    end else begin
      if (s_awvalid && s_awready) begin
        aw_held <= 1'b1;
        aw_off  <= {s_awaddr[5:2], 2'b00};
      end
      if (s_wvalid && s_wready) begin
        w_held <= 1'b1;
        w_data <= s_wdata;
        w_strb <= s_wstrb;
      end
      if (commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        s_bvalid <= 1'b1;
        s_bresp  <= is_mapped(aw_off) ? RESP_OKAY : RESP_SLVERR;
      end else if (s_bvalid && s_bready) begin
        s_bvalid <= 1'b0;
      end
    end
  end

  // Done edges set pending flags; a simultaneous W1C loses to the set
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      start_rx    <= 1'b0;
      start_tx    <= 1'b0;
      irq_en_rx   <= 1'b0;
      irq_en_tx   <= 1'b0;
      src_addr_rx <= '0;
      len_pkts_rx <= '0;
      dst_addr_tx <= '0;
      len_pkts_tx <= '0;
      rx_pend     <= 1'b0;
      tx_pend     <= 1'b0;
      rx_err      <= 1'b0;
      tx_err      <= 1'b0;
      done_rx_q   <= 1'b0;
      done_tx_q   <= 1'b0;
      irq         <= 1'b0;
    end else begin
      start_rx <= ctrl_wr && w_data[CTRL_START_RX] && !busy_rx;
      start_tx <= ctrl_wr && w_data[CTRL_START_TX] && !busy_tx;
      if (ctrl_wr) begin
        irq_en_rx <= w_data[CTRL_IRQ_EN_RX];
        irq_en_tx <= w_data[CTRL_IRQ_EN_TX];
      end
      if (commit) begin
        case (aw_off)
          REG_RX_SRC_LO: src_addr_rx[31:0]  <= apply_wstrb(src_addr_rx[31:0], w_data, w_strb);
          REG_RX_SRC_HI: src_addr_rx[63:32] <= apply_wstrb(src_addr_rx[63:32], w_data, w_strb);
          REG_RX_LEN:    len_pkts_rx        <= apply_wstrb(len_pkts_rx, w_data, w_strb);
          REG_TX_DST_LO: dst_addr_tx[31:0]  <= apply_wstrb(dst_addr_tx[31:0], w_data, w_strb);
          REG_TX_DST_HI: dst_addr_tx[63:32] <= apply_wstrb(dst_addr_tx[63:32], w_data, w_strb);
          REG_TX_LEN:    len_pkts_tx        <= apply_wstrb(len_pkts_tx, w_data, w_strb);
          default: ;
        endcase
      end
      done_rx_q <= done_rx;
      done_tx_q <= done_tx;
      rx_pend   <= (rx_pend && !w1c[ST_RX_PEND]) || (done_rx && !done_rx_q);
      tx_pend   <= (tx_pend && !w1c[ST_TX_PEND]) || (done_tx && !done_tx_q);
      rx_err    <= (rx_err && !w1c[ST_RX_START_ERR]) || (ctrl_wr && w_data[CTRL_START_RX] && busy_rx);
      tx_err    <= (tx_err && !w1c[ST_TX_START_ERR]) || (ctrl_wr && w_data[CTRL_START_TX] && busy_tx);
      irq       <= (rx_pend && irq_en_rx) || (tx_pend && irq_en_tx);
    end
  end

  always_comb begin
    rd_data = '0;
    case (ar_off)
      REG_CTRL: begin
        rd_data[CTRL_IRQ_EN_RX] = irq_en_rx;
        rd_data[CTRL_IRQ_EN_TX] = irq_en_tx;
      end
      REG_STATUS:    rd_data[7:0] = {tx_err, rx_err, tx_pend, rx_pend,
                                     done_tx, busy_tx, done_rx, busy_rx};
      REG_RX_SRC_LO: rd_data = src_addr_rx[31:0];
      REG_RX_SRC_HI: rd_data = src_addr_rx[63:32];
      REG_RX_LEN:    rd_data = len_pkts_rx;
      REG_TX_DST_LO: rd_data = dst_addr_tx[31:0];
      REG_TX_DST_HI: rd_data = dst_addr_tx[63:32];
      REG_TX_LEN:    rd_data = len_pkts_tx;
      REG_ID:        rd_data = ID_VALUE;
      default:       rd_data = '0;
    endcase
  end

  // Read data is captured on the AR handshake edge and held until taken
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_rvalid <= 1'b0;
      s_rdata  <= '0;
      s_rresp  <= RESP_OKAY;
    end else if (s_arvalid && s_arready) begin
      s_rvalid <= 1'b1;
      s_rdata  <= rd_data;
      s_rresp  <= is_mapped(ar_off) ? RESP_OKAY : RESP_SLVERR;
    end else if (s_rvalid && s_rready) begin
      s_rvalid <= 1'b0;
    end
  end

endmodule
